// File: rtl/pwl_sampler_pkg.sv
`timescale 1ns/1ps
// pwl_sampler_pkg: shared types, limits and the time-conversion helper for
// the PWL clocked sampler.
package pwl_sampler_pkg;

    // Sampler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest legal block length and drop-counter saturation value
    localparam int NAVG_MAX = 256;
    localparam int DROP_MAX = 255;

    // Sample counter width, wide enough to hold NAVG_MAX
    localparam int CNT_W = $clog2(NAVG_MAX + 1);

    // All sampler files use a 1 ns time unit, so $realtime is in ns
    localparam real TIME_UNIT_S = 1.0e-9;

    // Convert a simulation time value (in the 1 ns unit) into seconds
    function automatic real time_to_s(input real t_units);
        return t_units * TIME_UNIT_S;
    endfunction

endpackage

// File: rtl/pwl_sampler_eval.sv
`timescale 1ns/1ps
// pwl_sampler_eval: evaluates the PWL stimulus a + b*(t - t0) at each rising
// clock edge and holds the result until the next edge. This register is the
// sampler's instantaneous sample output.
module pwl_sampler_eval
    import pwl_sampler_pkg::*;
(
    input  logic i_clk,
    input  logic i_rstn,
    input  real  i_a,
    input  real  i_b,
    input  real  i_t0,
    output real  o_val
);

    real r_val;

    // Capture the PWL value at the time of this edge, every edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_val <= 0.0;
        end else begin
            r_val <= i_a + i_b * (time_to_s($realtime) - i_t0);
        end
    end

    assign o_val = r_val;

endmodule

// File: rtl/pwl_clk_sampler.sv
`timescale 1ns/1ps
// pwl_clk_sampler: clocked sampler of a piecewise-linear stimulus with
// NAVG-sample block averaging, valid/ready result hold, saturating drop
// counter and an optional hysteresis comparator. Define PWL_SAMPLER_HYST_EN
// to build the comparator; otherwise o_cmp is tied low.
//
// The PWL value of an edge only exists once that edge has happened, so the
// sample register (in pwl_sampler_eval) and this FSM update on the same
// edge. Anything that needs the newest sample -- the last term of a block
// sum, the comparator decision -- is folded in combinationally from the
// sample register and committed to state on the following edge.
module pwl_clk_sampler
    import pwl_sampler_pkg::*;
#(
    parameter int  NAVG   = 4,
    parameter real VTH_HI = 0.6,
    parameter real VTH_LO = 0.4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_en,
    input  real        i_in_a,
    input  real        i_in_b,
    input  real        i_in_t0,
    output real        o_smp,
    output real        o_avg,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_drop_cnt,
    output logic       o_cmp
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NAVG - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [7:0]       DROP_SAT = 8'(DROP_MAX);
    localparam real              NAVG_R   = real'(NAVG);

    // Reject parameter sets outside the supported range at elaboration
    generate
        if (NAVG < 1 || NAVG > NAVG_MAX || !(VTH_LO < VTH_HI)) begin : g_bad_params
            $error("pwl_clk_sampler: illegal NAVG or threshold parameters");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;       // samples accumulated in the open block
    logic             r_valid;
    logic [7:0]       r_drop_cnt;
    real              r_sum;       // block sum excluding the newest sample
    logic             r_take;      // newest sample belongs to the open block
    logic             r_fin;       // newest sample closed a block
    real              r_avg;       // committed average of an older block

    real w_smp;
    real w_full_sum;
    real w_fresh_avg;

    pwl_sampler_eval u_eval (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_a    (i_in_a),
        .i_b    (i_in_b),
        .i_t0   (i_in_t0),
        .o_val  (w_smp)
    );

    // Block sum including the newest sample, and the average it implies
    always_comb begin
        w_full_sum  = r_take ? (r_sum + w_smp) : r_sum;
        w_fresh_avg = w_full_sum / NAVG_R;
    end

    // Sampler FSM: block accumulation, result hold and drop counting
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_drop_cnt <= '0;
            r_sum      <= 0.0;
            r_take     <= 1'b0;
            r_fin      <= 1'b0;
            r_avg      <= 0.0;
        end else begin
            // A block closed on the previous edge: its last sample is now in
            // the sample register, so the average can be committed
            if (r_fin) begin
                r_avg <= w_fresh_avg;
            end
            r_fin <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_sum  <= 0.0;
                    r_take <= 1'b0;
                    if (i_en) begin
                        r_take <= 1'b1;
                        if (NAVG == 1) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                            r_fin   <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                            r_cnt   <= ONE_CNT;
                        end
                    end
                end

                ACCUM: begin
                    if (!i_en) begin
                        // Partial block is abandoned
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_sum   <= 0.0;
                        r_take  <= 1'b0;
                    end else begin
                        r_sum  <= w_full_sum;
                        r_take <= 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= HOLD;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                            r_fin   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    r_sum  <= 0.0;
                    r_take <= 1'b0;
                    r_cnt  <= '0;
                    if (i_ready) begin
                        // Consuming edge: its sample opens the next block
                        r_valid <= 1'b0;
                        if (!i_en) begin
                            r_state <= IDLE;
                        end else begin
                            r_take <= 1'b1;
                            if (NAVG == 1) begin
                                r_valid <= 1'b1;
                                r_fin   <= 1'b1;
                            end else begin
                                r_state <= ACCUM;
                                r_cnt   <= ONE_CNT;
                            end
                        end
                    end else if (r_drop_cnt != DROP_SAT) begin
                        r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_sum   <= 0.0;
                    r_take  <= 1'b0;
                end
            endcase
        end
    end

    assign o_smp      = w_smp;
    assign o_avg      = r_fin ? w_fresh_avg : r_avg;
    assign o_valid    = r_valid;
    assign o_drop_cnt = r_drop_cnt;

`ifdef PWL_SAMPLER_HYST_EN
    logic r_cmp_prev;   // comparator state before the newest sample
    logic r_cmp_live;   // at least one real sample has been taken
    logic w_cmp;

    // Hysteresis decision on the newest sample
    always_comb begin
        w_cmp = r_cmp_prev;
        if (r_cmp_live) begin
            if (w_smp > VTH_HI) begin
                w_cmp = 1'b1;
            end else if (w_smp < VTH_LO) begin
                w_cmp = 1'b0;
            end
        end
    end

    // Commit the comparator decision of the previous edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cmp_prev <= 1'b0;
            r_cmp_live <= 1'b0;
        end else begin
            r_cmp_prev <= w_cmp;
            r_cmp_live <= 1'b1;
        end
    end

    assign o_cmp = w_cmp;
`else
    assign o_cmp = 1'b0;
`endif

endmodule

// File: doc/pwl_clk_sampler.md
PWL_CLK_SAMPLER -- requirements
Module: pwl_clk_sampler

Interface
REQ-001 Parameter NAVG, default 4, number of clocked samples averaged per output (legal 1..256).
REQ-002 Parameter VTH_HI, default 0.6, real upper comparator threshold.
REQ-003 Parameter VTH_LO, default 0.4, real lower comparator threshold (VTH_LO < VTH_HI).
REQ-004 clk  input  1  sampling clock; all state updates on posedge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  sampling enable.
REQ-007 in  input  pwl  PWL stimulus (offset a, slope b, start time t0), e.g. a PWL filter output.
REQ-008 smp  output  real  instantaneous sample at the last posedge.
REQ-009 avg  output  real  mean of the last completed NAVG-sample block.
REQ-010 valid  output  1  avg holds an unconsumed result.
REQ-011 ready  input  1  downstream accepts avg.
REQ-012 drop_cnt  output  8  saturating count of samples discarded while stalled.
REQ-013 cmp  output  1  hysteresis comparator output.

Function
REQ-014 At each posedge, sample value SHALL be in.a + in.b*(t_now - in.t0), time in seconds via the codebase time-conversion helper; smp SHALL update every posedge, regardless of en.
REQ-015 FSM states SHALL be IDLE, ACCUM, HOLD.
REQ-016 IDLE: accumulator and count cleared; en=1 at posedge -> ACCUM, and that posedge's sample is the first accumulated.
REQ-017 ACCUM: add sample, increment count; when count reaches NAVG, avg = sum/NAVG, valid=1, go HOLD on the same edge.
REQ-018 NAVG=1: every accumulated sample SHALL complete a block, so avg updates one cycle after entering ACCUM.
REQ-019 HOLD: valid stays 1 and avg stable until the posedge with ready=1; that edge clears valid, and its sample starts the next block (ACCUM, count=1).
REQ-020 HOLD with ready=0: the sample is discarded; drop_cnt increments, saturating at 255.
REQ-021 en=0 in ACCUM: partial sum discarded, go IDLE; en=0 in HOLD: stay HOLD until consumed, then IDLE.
REQ-022 valid SHALL never drop without a ready handshake, except on reset.
REQ-023 Result latency: valid rises on the posedge of the NAVG-th accumulated sample.
REQ-024 Sum SHALL be a real accumulator; no overflow handling.

Reset
REQ-025 rstn=0 SHALL immediately set state IDLE, smp=0.0, avg=0.0, valid=0, drop_cnt=0, cmp=0, count=0, sum=0.0.
REQ-026 Reset asserted mid-block or in HOLD SHALL discard all pending data; first sample after release starts a fresh block.

Configuration
REQ-027 Macro PWL_SAMPLER_HYST_EN defined: cmp sets to 1 when smp > VTH_HI, clears to 0 when smp < VTH_LO, holds otherwise, updated each posedge.
REQ-028 Macro undefined: cmp SHALL be constant 0, and no comparator logic SHALL be present.

Structure
REQ-029 Package pwl_sampler_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD), NAVG_MAX=256, DROP_MAX=255.
REQ-030 Sub-module pwl_sampler_eval SHALL compute the PWL value at the current time; the FSM, averaging, and comparator live in pwl_clk_sampler.

Verification
REQ-031 NAVG=4, in const a=0.5 b=0, en=1, ready=1 -> avg=0.5, valid pulses 1 cycle every 4 posedges.
REQ-032 NAVG=4, 1 ns clk, ramp b=1e8 V/s from 0 at first edge -> smp=0,0.1,0.2,0.3; avg=0.15 at 4th edge.
REQ-033 ready=0 for 10 cycles after valid -> avg stable, drop_cnt=10; ready=0 for 300 cycles -> drop_cnt=255.
REQ-034 rstn low after 2 of 4 samples -> all outputs reset; after release, next valid only after 4 new samples.
REQ-035 HYST_EN, smp ramps 0->1->0 -> cmp rises at first sample >0.6, falls at first sample <0.4; no toggle within 0.4..0.6.
REQ-036 en dropped after 2 samples -> state IDLE, no valid; re-enable -> full 4-sample block before valid.
